// File: rtl/pkt_injector.sv
// Merges the upstream datapath stream with locally injected, fully buffered packets
// onto the module bus; sources switch only at packet boundaries, round-robin.
`timescale 1ns/1ps
module pkt_injector #(
  parameter int unsigned DATA_WIDTH         = 64,
  parameter int unsigned CTRL_WIDTH         = DATA_WIDTH/8,
  parameter int unsigned IN_FIFO_DEPTH_BITS = 2,
  parameter int unsigned INJ_DEPTH_BITS     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] inj_data,
  input  logic [CTRL_WIDTH-1:0] inj_ctrl,
  input  logic                  inj_wr,
  output logic                  inj_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [31:0]           pass_pkts,
  output logic [31:0]           inj_pkts,
  output logic [31:0]           inj_drops
);

  localparam int unsigned PASS_DEPTH = 1 << IN_FIFO_DEPTH_BITS;
  localparam int unsigned INJ_DEPTH  = 1 << INJ_DEPTH_BITS;
  localparam logic [IN_FIFO_DEPTH_BITS-1:0] PPTR_ONE = IN_FIFO_DEPTH_BITS'(1);
  localparam logic [IN_FIFO_DEPTH_BITS:0]   PCNT_ONE = (IN_FIFO_DEPTH_BITS+1)'(1);
  localparam logic [IN_FIFO_DEPTH_BITS:0]   PASS_NF  = (IN_FIFO_DEPTH_BITS+1)'(PASS_DEPTH - 1);
  localparam logic [INJ_DEPTH_BITS-1:0]     IPTR_ONE = INJ_DEPTH_BITS'(1);
  localparam logic [INJ_DEPTH_BITS:0]       ICNT_ONE = (INJ_DEPTH_BITS+1)'(1);
  localparam logic [INJ_DEPTH_BITS:0]       INJ_FULL = (INJ_DEPTH_BITS+1)'(INJ_DEPTH);
  localparam logic [INJ_DEPTH_BITS:0]       INJ_LAST = (INJ_DEPTH_BITS+1)'(INJ_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, PASS, INJECT} state_t;

  state_t state, state_nx, last_grant, last_grant_nx;
  logic   alive;

  // pass-through fallthrough FIFO
  logic [DATA_WIDTH-1:0]         pass_data_mem [PASS_DEPTH];
  logic [CTRL_WIDTH-1:0]         pass_ctrl_mem [PASS_DEPTH];
  logic [IN_FIFO_DEPTH_BITS-1:0] pass_wr_ptr, pass_rd_ptr;
  logic [IN_FIFO_DEPTH_BITS:0]   pass_count;
  logic                          pass_in_payload, pass_push, pass_pop, pass_empty, pass_eop;
  logic [DATA_WIDTH-1:0]         pass_head_data;
  logic [CTRL_WIDTH-1:0]         pass_head_ctrl;

  // injection buffer
  logic [DATA_WIDTH-1:0]     inj_data_mem [INJ_DEPTH];
  logic [CTRL_WIDTH-1:0]     inj_ctrl_mem [INJ_DEPTH];
  logic [INJ_DEPTH_BITS-1:0] inj_wr_ptr, inj_pkt_start, inj_rd_ptr, inj_rd_next;
  logic [INJ_DEPTH_BITS:0]   inj_used, inj_used_nx, inj_pkt_len, pkts_ready;
  logic                      inj_dropping, inj_wr_payload, inj_rd_payload;
  logic                      inj_accept, inj_store, inj_wr_eop, inj_commit, inj_overflow, inj_drop_done;
  logic                      inj_pop, inj_head_valid, inj_head_eop;
  logic [DATA_WIDTH-1:0]     inj_head_data;
  logic [CTRL_WIDTH-1:0]     inj_head_ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  assign in_rdy         = alive && (pass_count < PASS_NF);
  assign pass_push      = in_wr && in_rdy;
  assign pass_empty     = (pass_count == '0);
  assign pass_head_data = pass_data_mem[pass_rd_ptr];
  assign pass_head_ctrl = pass_ctrl_mem[pass_rd_ptr];
  assign pass_eop       = (pass_head_ctrl != '0) && pass_in_payload;

  assign inj_rdy        = alive && !((inj_used == INJ_FULL) && (pkts_ready != '0));
  assign inj_accept     = inj_wr && inj_rdy;
  assign inj_wr_eop     = (inj_ctrl != '0) && inj_wr_payload;
  assign inj_store      = inj_accept && !inj_dropping;
  assign inj_commit     = inj_store && inj_wr_eop;
  assign inj_overflow   = inj_store && !inj_wr_eop && (inj_pkt_len == INJ_LAST);
  assign inj_drop_done  = inj_accept && inj_dropping && inj_wr_eop;
  assign inj_rd_next    = inj_pop ? inj_rd_ptr + IPTR_ONE : inj_rd_ptr;
  assign inj_head_valid = (pkts_ready != '0);
  assign inj_head_eop   = (inj_head_ctrl != '0) && inj_rd_payload;

  // Storage has no reset; the injection head is re-read every cycle so it always
  // reflects the word at rd_ptr one cycle after any pointer move.
  always_ff @(posedge clk) begin
    if (pass_push) begin
      pass_data_mem[pass_wr_ptr] <= in_data;
      pass_ctrl_mem[pass_wr_ptr] <= in_ctrl;
    end
    if (inj_store) begin
      inj_data_mem[inj_wr_ptr] <= inj_data;
      inj_ctrl_mem[inj_wr_ptr] <= inj_ctrl;
    end
    inj_head_data <= inj_data_mem[inj_rd_next];
    inj_head_ctrl <= inj_ctrl_mem[inj_rd_next];
  end

  // After any word the payload flag is simply "that word had ctrl==0".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_wr_ptr     <= '0;
      pass_rd_ptr     <= '0;
      pass_count      <= '0;
      pass_in_payload <= 1'b0;
    end else begin
      if (pass_push) pass_wr_ptr <= pass_wr_ptr + PPTR_ONE;
      if (pass_pop) begin
        pass_rd_ptr     <= pass_rd_ptr + PPTR_ONE;
        pass_in_payload <= (pass_head_ctrl == '0);
      end
      case ({pass_push, pass_pop})
        2'b10:   pass_count <= pass_count + PCNT_ONE;
        2'b01:   pass_count <= pass_count - PCNT_ONE;
        default: pass_count <= pass_count;
      endcase
    end
  end

  always_comb begin
    inj_used_nx = inj_used;
    if (inj_store && !inj_overflow) inj_used_nx = inj_used_nx + ICNT_ONE;
    if (inj_overflow)               inj_used_nx = inj_used_nx - inj_pkt_len;
    if (inj_pop)                    inj_used_nx = inj_used_nx - ICNT_ONE;
  end

  // The commit pointer always equals pkt_start, so one register serves both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_wr_ptr     <= '0;
      inj_pkt_start  <= '0;
      inj_rd_ptr     <= '0;
      inj_used       <= '0;
      inj_pkt_len    <= '0;
      pkts_ready     <= '0;
      inj_dropping   <= 1'b0;
      inj_wr_payload <= 1'b0;
      inj_rd_payload <= 1'b0;
      inj_drops      <= '0;
    end else begin
      if (inj_accept) inj_wr_payload <= (inj_ctrl == '0);
      if (inj_commit) begin
        inj_wr_ptr    <= inj_wr_ptr + IPTR_ONE;
        inj_pkt_start <= inj_wr_ptr + IPTR_ONE;
        inj_pkt_len   <= '0;
      end else if (inj_overflow) begin
        inj_wr_ptr   <= inj_pkt_start;
        inj_pkt_len  <= '0;
        inj_dropping <= 1'b1;
      end else if (inj_store) begin
        inj_wr_ptr  <= inj_wr_ptr + IPTR_ONE;
        inj_pkt_len <= inj_pkt_len + ICNT_ONE;
      end
      if (inj_drop_done) begin
        inj_dropping <= 1'b0;
        inj_drops    <= inj_drops + 32'd1;
      end
      if (inj_pop) begin
        inj_rd_ptr     <= inj_rd_ptr + IPTR_ONE;
        inj_rd_payload <= (inj_head_ctrl == '0);
      end
      inj_used <= inj_used_nx;
      case ({inj_commit, inj_pop && inj_head_eop})
        2'b10:   pkts_ready <= pkts_ready + ICNT_ONE;
        2'b01:   pkts_ready <= pkts_ready - ICNT_ONE;
        default: pkts_ready <= pkts_ready;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= INJECT;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    out_wr        = 1'b0;
    out_data      = '0;
    out_ctrl      = '0;
    pass_pop      = 1'b0;
    inj_pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!pass_empty && inj_head_valid) begin
          state_nx      = (last_grant == INJECT) ? PASS : INJECT;
          last_grant_nx = state_nx;
        end else if (!pass_empty) begin
          state_nx      = PASS;
          last_grant_nx = PASS;
        end else if (inj_head_valid) begin
          state_nx      = INJECT;
          last_grant_nx = INJECT;
        end
      end
      PASS: begin
        out_data = pass_head_data;
        out_ctrl = pass_head_ctrl;
        if (!pass_empty && out_rdy) begin
          out_wr   = 1'b1;
          pass_pop = 1'b1;
          if (pass_eop) state_nx = IDLE;
        end
      end
      INJECT: begin
        out_data = inj_head_data;
        out_ctrl = inj_head_ctrl;
        if (inj_head_valid && out_rdy) begin
          out_wr  = 1'b1;
          inj_pop = 1'b1;
          if (inj_head_eop) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_pkts <= '0;
      inj_pkts  <= '0;
    end else begin
      if (pass_pop && pass_eop)    pass_pkts <= pass_pkts + 32'd1;
      if (inj_pop && inj_head_eop) inj_pkts  <= inj_pkts + 32'd1;
    end
  end

endmodule

// File: tb/tb_pkt_injector.sv
// Directed bench for pkt_injector (injection buffer depth 16).
`timescale 1ns/1ps
module tb_pkt_injector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_data = '0, inj_data = '0, out_data;
  logic [7:0]  in_ctrl = '0, inj_ctrl = '0, out_ctrl;
  logic        in_wr = 1'b0, inj_wr = 1'b0, out_rdy = 1'b0;
  logic        in_rdy, inj_rdy, out_wr;
  logic [31:0] pass_pkts, inj_pkts, inj_drops;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;

  logic [63:0] cap_data[$];
  logic [7:0]  cap_ctrl[$];
  int unsigned cap_cyc[$];
  logic [63:0] exp_data[$];
  logic [7:0]  exp_ctrl[$];

  always #5 clk = ~clk;

  pkt_injector #(
    .DATA_WIDTH(64),
    .CTRL_WIDTH(8),
    .IN_FIFO_DEPTH_BITS(2),
    .INJ_DEPTH_BITS(4)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .inj_data(inj_data), .inj_ctrl(inj_ctrl), .inj_wr(inj_wr), .inj_rdy(inj_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .pass_pkts(pass_pkts), .inj_pkts(inj_pkts), .inj_drops(inj_drops)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_wr === 1'b1) begin
      cap_data.push_back(out_data);
      cap_ctrl.push_back(out_ctrl);
      cap_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pdata(input int unsigned p, input int unsigned i);
    return 64'hA0A0_0000_0000_0000 | (64'(p) << 16) | 64'(i);
  endfunction
  function automatic logic [7:0] pctrl(input int unsigned i);
    case (i)
      0: return 8'hFF;
      1: return 8'h04;
      5: return 8'h80;
      default: return 8'h00;
    endcase
  endfunction
  function automatic logic [63:0] idata(input int unsigned p, input int unsigned i);
    return 64'h1E1E_0000_0000_0000 | (64'(p) << 16) | 64'(i);
  endfunction
  function automatic logic [7:0] ictrl(input int unsigned i, input int unsigned n);
    if (i == 0) return 8'hFF;
    if (i == n - 1) return 8'h01;
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pass(input logic [63:0] d, input logic [7:0] c);
    int unsigned w = 0;
    while (in_rdy !== 1'b1 && w < 200) begin tick(); w++; end
    if (w >= 200) check("in_rdy_wait", 64'(in_rdy), 64'd1);
    in_data = d; in_ctrl = c; in_wr = 1'b1;
    tick();
    in_wr = 1'b0;
  endtask

  task automatic send_inj(input logic [63:0] d, input logic [7:0] c);
    int unsigned w = 0;
    while (inj_rdy !== 1'b1 && w < 200) begin tick(); w++; end
    if (w >= 200) check("inj_rdy_wait", 64'(inj_rdy), 64'd1);
    inj_data = d; inj_ctrl = c; inj_wr = 1'b1;
    tick();
    inj_wr = 1'b0;
  endtask

  task automatic send_pass_pkt(input int unsigned p);
    for (int unsigned i = 0; i < 6; i++) send_pass(pdata(p, i), pctrl(i));
  endtask
  task automatic send_inj_pkt(input int unsigned p, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send_inj(idata(p, i), ictrl(i, n));
  endtask
  task automatic expect_pass_pkt(input int unsigned p);
    for (int unsigned i = 0; i < 6; i++) begin
      exp_data.push_back(pdata(p, i)); exp_ctrl.push_back(pctrl(i));
    end
  endtask
  task automatic expect_inj_pkt(input int unsigned p, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      exp_data.push_back(idata(p, i)); exp_ctrl.push_back(ictrl(i, n));
    end
  endtask

  task automatic clear_q();
    cap_data.delete(); cap_ctrl.delete(); cap_cyc.delete();
    exp_data.delete(); exp_ctrl.delete();
  endtask

  task automatic wait_out(input string tag, input int unsigned n, input int unsigned limit);
    int unsigned w = 0;
    while (cap_data.size() < n && w < limit) begin tick(); w++; end
    tick();
    check({tag, "_count"}, 64'(cap_data.size()), 64'(n));
  endtask

  task automatic compare_out(input string tag);
    int unsigned n;
    n = (cap_data.size() < exp_data.size()) ? cap_data.size() : exp_data.size();
    for (int unsigned i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), cap_data[i], exp_data[i]);
      check($sformatf("%s_ctrl%0d", tag, i), 64'(cap_ctrl[i]), 64'(exp_ctrl[i]));
    end
    clear_q();
  endtask

  task automatic do_reset();
    in_wr = 1'b0; inj_wr = 1'b0; out_rdy = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    clear_q();
  endtask

  initial begin
    int unsigned w;
    logic rdy_pat [8];

    // reset state
    #2;
    check("rst_out_wr", 64'(out_wr), 64'd0);
    check("rst_in_rdy", 64'(in_rdy), 64'd0);
    check("rst_inj_rdy", 64'(inj_rdy), 64'd0);
    check("rst_pass_pkts", 64'(pass_pkts), 64'd0);
    check("rst_inj_pkts", 64'(inj_pkts), 64'd0);
    check("rst_inj_drops", 64'(inj_drops), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    #1;
    check("rel_in_rdy_pre_edge", 64'(in_rdy), 64'd0);
    tick();
    check("rel_in_rdy", 64'(in_rdy), 64'd1);
    check("rel_inj_rdy", 64'(inj_rdy), 64'd1);

    // pass only: 3 packets, one bubble between packets
    out_rdy = 1'b1;
    for (int unsigned p = 0; p < 3; p++) begin
      expect_pass_pkt(p);
      send_pass_pkt(p);
    end
    wait_out("pass", 18, 200);
    if (cap_cyc.size() >= 18) begin
      check("pass_gap1", 64'(cap_cyc[6] - cap_cyc[5]), 64'd2);
      check("pass_gap2", 64'(cap_cyc[12] - cap_cyc[11]), 64'd2);
    end
    compare_out("pass");
    check("pass_pass_pkts", 64'(pass_pkts), 64'd3);
    check("pass_inj_pkts", 64'(inj_pkts), 64'd0);

    // contention: both pending in IDLE with last grant INJECT -> pass first
    do_reset();
    out_rdy = 1'b1;
    for (int unsigned i = 0; i < 7; i++) send_inj(idata(0, i), ictrl(i, 8));
    inj_data = idata(0, 7); inj_ctrl = ictrl(7, 8); inj_wr = 1'b1;
    in_data = pdata(0, 0); in_ctrl = pctrl(0); in_wr = 1'b1;
    tick();
    inj_wr = 1'b0; in_wr = 1'b0;
    for (int unsigned i = 1; i < 6; i++) send_pass(pdata(0, i), pctrl(i));
    expect_pass_pkt(0);
    expect_inj_pkt(0, 8);
    wait_out("cont", 14, 200);
    compare_out("cont");
    check("cont_pass_pkts", 64'(pass_pkts), 64'd1);
    check("cont_inj_pkts", 64'(inj_pkts), 64'd1);

    // back-pressure during an inject packet
    out_rdy = 1'b0;
    expect_inj_pkt(1, 6);
    send_inj_pkt(1, 6);
    repeat (3) tick();
    check("bp_hold_out_wr", 64'(out_wr), 64'd0);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int unsigned k = 0; k < 8; k++) begin
      out_rdy = rdy_pat[k];
      #1;
      check($sformatf("bp_out_wr%0d", k), 64'(out_wr), 64'(rdy_pat[k]));
      tick();
    end
    out_rdy = 1'b1;
    wait_out("bp", 6, 50);
    compare_out("bp");
    check("bp_inj_pkts", 64'(inj_pkts), 64'd2);

    // oversize: 20-word inject packet into a 16-word buffer is dropped
    do_reset();
    out_rdy = 1'b1;
    send_inj_pkt(2, 20);
    check("ovs_inj_rdy", 64'(inj_rdy), 64'd1);
    repeat (6) tick();
    check("ovs_nothing_out", 64'(cap_data.size()), 64'd0);
    check("ovs_drops", 64'(inj_drops), 64'd1);
    check("ovs_inj_pkts0", 64'(inj_pkts), 64'd0);
    expect_inj_pkt(3, 5);
    send_inj_pkt(3, 5);
    wait_out("ovs", 5, 50);
    compare_out("ovs");
    check("ovs_inj_pkts1", 64'(inj_pkts), 64'd1);
    check("ovs_drops_after", 64'(inj_drops), 64'd1);

    // wrap/full: 16 words fill the buffer while output is stalled
    out_rdy = 1'b0;
    for (int unsigned p = 4; p < 8; p++) begin
      expect_inj_pkt(p, 4);
      for (int unsigned i = 0; i < 4; i++) begin
        if (p == 7 && i == 3) check("full_rdy_before_16", 64'(inj_rdy), 64'd1);
        send_inj(idata(p, i), ictrl(i, 4));
      end
    end
    check("full_rdy_after_16", 64'(inj_rdy), 64'd0);
    check("full_out_wr", 64'(out_wr), 64'd0);
    out_rdy = 1'b1;
    wait_out("full", 16, 200);
    compare_out("full");
    check("full_inj_pkts", 64'(inj_pkts), 64'd5);
    for (int unsigned p = 8; p < 12; p++) begin
      expect_inj_pkt(p, 4);
      send_inj_pkt(p, 4);
    end
    wait_out("wrap", 16, 200);
    compare_out("wrap");
    check("wrap_inj_pkts", 64'(inj_pkts), 64'd9);

    // async reset in the middle of an inject packet
    out_rdy = 1'b1;
    send_inj_pkt(12, 8);
    w = 0;
    while (out_wr !== 1'b1 && w < 50) begin tick(); w++; end
    check("ar_started", 64'(out_wr), 64'd1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("ar_out_wr", 64'(out_wr), 64'd0);
    check("ar_in_rdy", 64'(in_rdy), 64'd0);
    check("ar_inj_rdy", 64'(inj_rdy), 64'd0);
    check("ar_pass_pkts", 64'(pass_pkts), 64'd0);
    check("ar_inj_pkts", 64'(inj_pkts), 64'd0);
    check("ar_inj_drops", 64'(inj_drops), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("ar_rel_in_rdy", 64'(in_rdy), 64'd1);
    clear_q();
    expect_pass_pkt(9);
    send_pass_pkt(9);
    wait_out("ar", 6, 100);
    compare_out("ar");
    check("ar_pass_pkts_after", 64'(pass_pkts), 64'd1);
    check("ar_inj_pkts_after", 64'(inj_pkts), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_injector.md
# pkt_injector

Source-side merge block for the user data path: it transmits packets onto the standard `out_data/out_ctrl/out_wr/out_rdy` module bus, merging the upstream datapath stream with locally generated packets (e.g. controller packet-outs). Injected packets are fully buffered (store-and-forward) before transmission, so neither source ever stalls the output mid-packet. Source switches happen only at packet boundaries, with round-robin arbitration. It sits directly upstream of the matcher stage and drives that stage's input bus.

## Interface
- `DATA_WIDTH`, 64, bus data width.
- `CTRL_WIDTH`, DATA_WIDTH/8, bus ctrl width.
- `IN_FIFO_DEPTH_BITS`, 2, log2 depth of the pass-through fallthrough FIFO.
- `INJ_DEPTH_BITS`, 8, log2 depth (in words) of the injection buffer.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `in_data`  in  DATA_WIDTH  upstream datapath word.
- `in_ctrl`  in  CTRL_WIDTH  upstream ctrl.
- `in_wr`  in  1  upstream word valid; legal only when `in_rdy`=1.
- `in_rdy`  out  1  = !pass FIFO nearly_full.
- `inj_data`  in  DATA_WIDTH  injected packet word.
- `inj_ctrl`  in  CTRL_WIDTH  injected ctrl.
- `inj_wr`  in  1  injected word valid; legal only when `inj_rdy`=1.
- `inj_rdy`  out  1  injection buffer can accept a word.
- `out_data`  out  DATA_WIDTH  merged output word.
- `out_ctrl`  out  CTRL_WIDTH  merged output ctrl.
- `out_wr`  out  1  output word valid.
- `out_rdy`  in  1  downstream can accept a word.
- `pass_pkts`  out  32  packets transmitted from the datapath source.
- `inj_pkts`  out  32  packets transmitted from the injection source.
- `inj_drops`  out  32  injected packets discarded as oversize.

## Operation
- Packet framing: header words have ctrl≠0; first ctrl==0 word starts payload; the first ctrl≠0 word after any ctrl==0 word is EOP. Framing is tracked independently per source (flag `in_payload`, cleared at EOP and reset).
- Pass source: fallthrough FIFO, depth 2^IN_FIFO_DEPTH_BITS; head visible the cycle after write.
- Inject source: circular RAM, 2^INJ_DEPTH_BITS words, with pointers `wr_ptr` (in-progress packet), `pkt_start`, `commit_ptr`, `rd_ptr`. Writing EOP sets `commit_ptr`=`wr_ptr`+1 and increments `pkts_ready` (counts committed, untransmitted packets). Pointers wrap modulo depth.
- `inj_rdy`=0 only when the buffer is full and committed-but-unread words exist; otherwise 1.
- Oversize: if an in-progress packet reaches 2^INJ_DEPTH_BITS words without EOP, enter DROP: `wr_ptr` rewinds to `pkt_start`, words are accepted (`inj_rdy`=1) and discarded through EOP, then `inj_drops`++. The EOP-word cycle leaves DROP.
- FSM (IDLE, PASS, INJECT):
  - IDLE: if both sources are pending, grant the source not granted last; else grant whichever is pending. Pass is pending when its FIFO is non-empty; inject when `pkts_ready`>0. Granting takes one cycle (no output in the IDLE cycle).
  - PASS / INJECT: `out_wr` = source head valid && `out_rdy`; `out_data/out_ctrl` = source head. On transmitting EOP: bump the counter (`pass_pkts` / `inj_pkts`), decrement `pkts_ready` for inject, and return to IDLE.
- `out_wr` never asserts while `out_rdy`=0. Outputs are combinational from the selected head; `out_data/out_ctrl` are don't-care when `out_wr`=0.
- Counters wrap at 2^32.
- Simultaneous EOP write and EOP read on inject: `pkts_ready` is unchanged.

## Timing
- While reset is asserted: `out_wr`=0, `in_rdy`=0, `inj_rdy`=0, all counters 0, FSM=IDLE, all pointers 0, `pkts_ready`=0, last-grant=INJECT (so pass wins the first tie).
- Reset deassert: `in_rdy`/`inj_rdy`=1 from the first clock edge after deassertion.
- Reset asserted mid-packet: all buffered data is discarded. There is no partial-packet recovery; the downstream stage is reset with this block.
- Pass latency: word written at edge N is eligible for output at cycle N+1 if the FSM is already in PASS. From IDLE, first `out_wr` is at N+2.
- Inject latency: EOP written at edge N; IDLE grant at N+1; first word on out at N+2 (RAM read registered during the grant cycle). One word per cycle thereafter while `out_rdy`=1.
- Back-pressure: `out_rdy`=0 holds the current head word and all state. No word is lost or duplicated.

## Test plan
- Pass only: 3 packets of 2 header + 4 payload words (last ctrl=0x80), `out_rdy`=1 → identical words out in order, `pass_pkts`=3, one IDLE bubble between packets.
- Contention: 8-word inject packet committed while the pass FIFO holds a packet, FSM in IDLE, last grant INJECT → pass packet first, then inject. `pass_pkts`=1, `inj_pkts`=1, with no interleaving of words.
- Back-pressure: toggle `out_rdy` 1,0,0,1 during an inject packet → every word emitted exactly once, in order. `out_wr` is 0 in both stall cycles.
- Oversize: with `INJ_DEPTH_BITS`=4, write a 20-word inject packet → nothing transmitted, `inj_drops`=1. A following 5-word packet is transmitted intact with `inj_pkts`=1.
- Wrap/full: 4-word inject packets back-to-back with `out_rdy`=0 (depth 16) → `inj_rdy` falls after 16 words. Release `out_rdy` → 4 packets out intact, and pointers wrap correctly on the next 4.
- Async reset mid-inject-packet → outputs drop to reset values immediately. After release, a fresh pass packet flows with counters restarted at 0.
